// File: rtl/gb_pkg.sv
// Shared constants and types for the Gaussian-blur output path.
package gb_pkg;

    localparam int GB_PIX_W    = 8;
    localparam int GB_IN_COLS  = 488;
    localparam int GB_IN_ROWS  = 648;
    localparam int GB_STENCIL  = 9;

    // The 9-tap stencil drops 8 pixels per dimension, giving 480 x 640.
    localparam int GB_OUT_COLS = GB_IN_COLS - (GB_STENCIL - 1);
    localparam int GB_OUT_ROWS = GB_IN_ROWS - (GB_STENCIL - 1);

    typedef logic [GB_PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fr_state_t;

endpackage

// File: rtl/gb_out_framer_if.sv
// Stream bundle around the framer: core-side input stream (arg_0_*) and framed
// output stream (m_*). The slave modport is the framer's view; the master
// modport is the surrounding core/sink.
import gb_pkg::*;

interface gb_out_framer_if #(
    parameter int DATA_W = GB_PIX_W
);
    logic [DATA_W-1:0] arg_0_TDATA;
    logic              arg_0_TVALID;
    logic              arg_0_TREADY;
    logic [DATA_W-1:0] m_TDATA;
    logic              m_TVALID;
    logic              m_TREADY;
    logic              m_TUSER;
    logic              m_TLAST;

    modport slave (
        input  arg_0_TDATA, arg_0_TVALID, m_TREADY,
        output arg_0_TREADY, m_TDATA, m_TVALID, m_TUSER, m_TLAST
    );

    modport master (
        output arg_0_TDATA, arg_0_TVALID, m_TREADY,
        input  arg_0_TREADY, m_TDATA, m_TVALID, m_TUSER, m_TLAST
    );
endinterface

// File: rtl/gb_axis_fifo.sv
// Small registered FIFO, no bypass: a pushed word is readable the next cycle.
// Pushes while full and pops while empty are ignored.
import gb_pkg::*;

module gb_axis_fifo #(
    parameter int DATA_W = GB_PIX_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; storage cleared so dout reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/gb_out_framer.sv
// Output framer for the blur core: buffers the core stream in a FIFO and
// re-emits it with TUSER (start of frame), TLAST (end of row) and a
// frame_done pulse. Accepts at most one frame's worth of pixels per start.
import gb_pkg::*;

module gb_out_framer #(
    parameter int DATA_W     = GB_PIX_W,
    parameter int OUT_COLS   = GB_OUT_COLS,
    parameter int OUT_ROWS   = GB_OUT_ROWS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    gb_out_framer_if.slave      bus,
    output logic                frame_done,
    output logic                busy
);
    localparam int COL_W     = $clog2(OUT_COLS);
    localparam int ROW_W     = $clog2(OUT_ROWS);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME_PIX = OUT_COLS * OUT_ROWS;
    localparam int ACC_W     = $clog2(FRAME_PIX + 1);

    fr_state_t         state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  unused_fifo_count;
    logic              last_col;
    logic              last_row;

    gb_axis_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.arg_0_TDATA),
        .dout  (bus.m_TDATA),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    // TREADY uses the pre-pop occupancy, so a full FIFO never pushes and pops
    // in the same cycle.
    assign bus.arg_0_TREADY = (state_q == RUN) & ~fifo_full
                            & (acc_q < ACC_W'(FRAME_PIX));
    assign push             = bus.arg_0_TVALID & bus.arg_0_TREADY;
    assign bus.m_TVALID     = ~fifo_empty;
    assign pop              = bus.m_TVALID & bus.m_TREADY;

    assign last_col    = (col_q == COL_W'(OUT_COLS - 1));
    assign last_row    = (row_q == ROW_W'(OUT_ROWS - 1));
    assign bus.m_TUSER = bus.m_TVALID & (col_q == '0) & (row_q == '0);
    assign bus.m_TLAST = bus.m_TVALID & last_col;

    // Frame FSM next state and status outputs.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (pop && last_col && last_row) state_d = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output position counters and per-frame input tally.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        acc_d = acc_q;
        if (pop) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        if (state_q == DONE) begin
            acc_d = '0;
        end else if (push) begin
            acc_d = acc_q + ACC_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_gb_out_framer.sv
// Directed bench for gb_out_framer with a small 4x3 frame and 4-deep FIFO.
// Accepted input pixels are queued with their expected sideband and checked
// against the output stream as it is consumed.
module tb_gb_out_framer;
    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int DEPTH = 4;
    localparam int FRAME = COLS * ROWS;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
        logic       fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic frame_done;
    logic busy;

    gb_out_framer_if #(.DATA_W(8)) bus ();

    gb_out_framer #(
        .DATA_W     (8),
        .OUT_COLS   (COLS),
        .OUT_ROWS   (ROWS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [7:0] src_q[$];
    int   in_idx  = 0;
    int   in_cnt  = 0;
    int   out_cnt = 0;
    int   fd_cnt  = 0;
    logic in_hs   = 1'b0;
    logic out_hs  = 1'b0;
    logic fd_exp  = 1'b0;
    logic busy_low_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        int target;
        target = fd_cnt + 1;
        for (int i = 0; i < limit && fd_cnt < target; i++) sample();
        check("frame_done_seen", 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic push_src(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(first + 8'(i));
    endtask

    // Source model: present the head of src_q, advance after a handshake.
    always @(posedge clk) begin
        #1;
        if (in_hs && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0) begin
            bus.arg_0_TVALID = 1'b1;
            bus.arg_0_TDATA  = src_q[0];
        end else begin
            bus.arg_0_TVALID = 1'b0;
            bus.arg_0_TDATA  = 8'h00;
        end
    end

    // Monitor/scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        in_hs  = ~rst & bus.arg_0_TVALID & bus.arg_0_TREADY;
        out_hs = ~rst & bus.m_TVALID & bus.m_TREADY;
        if (!rst) begin
            check("frame_done", 32'(frame_done), 32'(fd_exp));
            if (busy_low_exp) check("busy_after_done", 32'(busy), 32'd0);
            if (frame_done) fd_cnt++;
            busy_low_exp = fd_exp;
            fd_exp = 1'b0;
            if (out_hs) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(bus.m_TDATA), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pixel", {22'd0, bus.m_TDATA, bus.m_TUSER, bus.m_TLAST},
                          {22'd0, e.data, e.user, e.last});
                    fd_exp = e.fin;
                end
            end
            if (in_hs) begin
                in_cnt++;
                e.data = bus.arg_0_TDATA;
                e.user = (in_idx == 0);
                e.last = ((in_idx % COLS) == COLS - 1);
                e.fin  = (in_idx == FRAME - 1);
                exp_q.push_back(e);
                in_idx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.arg_0_TVALID = 1'b0;
        bus.arg_0_TDATA  = 8'h00;
        bus.m_TREADY     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // 1: core offers data without start; framer stays quiet.
        push_src(8'h01, 12);
        tick();
        repeat (20) begin
            sample();
            check("idle_outputs",
                  {18'd0, bus.arg_0_TREADY, bus.m_TVALID, bus.m_TUSER, bus.m_TLAST,
                   bus.m_TDATA, frame_done, busy}, 32'd0);
        end

        // 2: one full frame with a free-running sink.
        tick();
        bus.m_TREADY = 1'b1;
        start = 1'b1;
        in_idx = 0;
        base = out_cnt;
        tick();
        start = 1'b0;
        sample();
        check("busy_in_run", 32'(busy), 32'd1);
        wait_done(200);
        repeat (4) sample();
        check("frame1_out_count", 32'(out_cnt - base), 32'd12);

        // 3: sink stalled; only the FIFO depth is accepted.
        tick();
        bus.m_TREADY = 1'b0;
        start = 1'b1;
        in_idx = 0;
        base = in_cnt;
        push_src(8'h21, 6);
        tick();
        start = 1'b0;
        repeat (10) sample();
        check("bp_accepted", 32'(in_cnt - base), 32'd4);
        check("bp_tready", 32'(bus.arg_0_TREADY), 32'd0);
        check("bp_count", 32'(dut.u_fifo.count), 32'd4);

        // 4: full FIFO popping this cycle still refuses input.
        tick();
        bus.m_TREADY = 1'b1;
        sample();
        check("full_pop_tready", {30'd0, bus.arg_0_TREADY, bus.m_TVALID}, 32'd1);
        sample();
        check("after_pop_tready", 32'(bus.arg_0_TREADY), 32'd1);
        check("after_pop_count", 32'(dut.u_fifo.count), 32'd3);
        push_src(8'h27, 6);
        wait_done(200);

        // 5: core over-supplies; surplus waits for the next start.
        tick();
        start = 1'b1;
        in_idx = 0;
        base = in_cnt;
        push_src(8'h31, 14);
        tick();
        start = 1'b0;
        wait_done(200);
        repeat (5) sample();
        check("surplus_accepted", 32'(in_cnt - base), 32'd12);
        check("surplus_held", {29'd0, bus.arg_0_TVALID, bus.arg_0_TREADY, bus.m_TVALID}, 32'd4);
        check("surplus_head", 32'(bus.arg_0_TDATA), 32'h3D);
        tick();
        start = 1'b1;
        in_idx = 0;
        push_src(8'h41, 10);
        tick();
        start = 1'b0;
        wait_done(200);

        // 6: reset in the middle of a frame, then a clean frame.
        tick();
        start = 1'b1;
        in_idx = 0;
        push_src(8'h51, 12);
        tick();
        start = 1'b0;
        base = out_cnt;
        for (int i = 0; i < 100 && (out_cnt - base) < 5; i++) sample();
        check("pre_reset_outputs", 32'((out_cnt - base) >= 5), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        in_idx = 0;
        sample();
        check("post_reset_state", {30'd0, bus.m_TVALID, busy}, 32'd0);
        repeat (3) tick();
        push_src(8'h61, 12);
        start = 1'b1;
        in_idx = 0;
        tick();
        start = 1'b0;
        wait_done(200);

        repeat (3) sample();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
